// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: FSM encoding and default limits.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam int MEM_TIMEOUT_DEF = 16;
    localparam int WAIT_W          = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, holding at all-ones once reached.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipe_stall_controller.sv
// Pipeline stall/flush controller: memory-wait freeze with timeout fault,
// branch flush and load-use bubble, plus saturating stall/flush statistics.
module pipe_stall_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lu_hazard,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [15:0]      flush_cnt
);

    localparam logic [WAIT_W-1:0] TIMEOUT_L = WAIT_W'(MEM_TIMEOUT);

    state_t            state_r;
    state_t            next_state_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_nxt_s;
    logic              run_path_s;
    logic              flush_inc_s;

    // Next-state and same-cycle pipeline control decode.
    always_comb begin
        next_state_s  = state_r;
        wait_nxt_s    = wait_cnt_r;
        run_path_s    = 1'b0;
        flush_inc_s   = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        fault         = 1'b0;
        case (state_r)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    wait_nxt_s    = {{(WAIT_W-1){1'b0}}, 1'b1};
                    next_state_s  = MEM_WAIT;
                end else begin
                    run_path_s    = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_ex_write   = 1'b0;
                    ex_mem_write  = 1'b0;
                    mem_wb_bubble = 1'b1;
                    wait_nxt_s    = wait_cnt_r + WAIT_W'(1);
                    if (wait_nxt_s >= TIMEOUT_L) begin
                        next_state_s = FAULT;
                    end else begin
                        next_state_s = MEM_WAIT;
                    end
                end else begin
                    // Access completes this cycle: release and behave as RUN.
                    run_path_s    = 1'b1;
                    wait_nxt_s    = '0;
                    next_state_s  = RUN;
                end
            end
            FAULT: begin
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                fault         = 1'b1;
            end
            default: begin
                // Corrupted state encoding is treated as a fault.
                pc_write      = 1'b0;
                if_id_write   = 1'b0;
                id_ex_write   = 1'b0;
                ex_mem_write  = 1'b0;
                fault         = 1'b1;
                next_state_s  = FAULT;
            end
        endcase

        if (run_path_s && branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_inc_s = 1'b1;
        end else if (run_path_s && lu_hazard) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            flush_inc_s = 1'b0;
        end
    end

    // FSM state and memory-wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_nxt_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (~pc_write),
        .count (stall_cnt)
    );

    sat_counter #(.W(16)) u_flush_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stall_controller.sv
// Directed bench for pipe_stall_controller: vector table plus multi-cycle
// memory-wait, timeout, reset and saturation sequences.
module tb_pipe_stall_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lu_hazard = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble, fault;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        pc_write4, if_id_write4, id_ex_write4, ex_mem_write4;
    logic        if_id_flush4, id_ex_flush4, mem_wb_bubble4, fault4;
    logic [3:0]  stall_cnt4;
    logic [15:0] flush_cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .lu_hazard(lu_hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
        .if_id_write(if_id_write), .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
        .fault(fault), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stall_controller #(.MEM_TIMEOUT(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .lu_hazard(lu_hazard), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write4),
        .if_id_write(if_id_write4), .id_ex_write(id_ex_write4), .ex_mem_write(ex_mem_write4),
        .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4), .mem_wb_bubble(mem_wb_bubble4),
        .fault(fault4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    // {pc, if_id_w, id_ex_w, ex_mem_w, if_id_fl, id_ex_fl, bubble, fault}
    logic [7:0] outs;
    assign outs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                   if_id_flush, id_ex_flush, mem_wb_bubble, fault};

    localparam logic [7:0] O_IDLE   = 8'b1111_0000;
    localparam logic [7:0] O_LU     = 8'b0011_0100;
    localparam logic [7:0] O_BR     = 8'b1111_1100;
    localparam logic [7:0] O_FREEZE = 8'b0000_0010;
    localparam logic [7:0] O_FAULT  = 8'b0000_0001;

    typedef struct packed {
        logic [3:0]  in;     // {lu, br, req, rdy}
        logic [7:0]  out;
        logic [31:0] stall;  // after this cycle's edge
        logic [15:0] flush;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs at the falling edge and let combinational outputs settle.
    task automatic drive(input logic [3:0] in);
        @(negedge clk);
        {lu_hazard, branch_taken, mem_req, mem_ready} = in;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        {lu_hazard, branch_taken, mem_req, mem_ready} = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear_stall", stall_cnt, 32'd0);
        check("async_clear_flush", {16'd0, flush_cnt}, 32'd0);
        check("async_clear_outs", {24'd0, outs}, {24'd0, O_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{4'b0000, O_IDLE,   32'd0, 16'd0};
        vecs[1]  = '{4'b1000, O_LU,     32'd1, 16'd0};
        vecs[2]  = '{4'b1100, O_BR,     32'd1, 16'd1};
        vecs[3]  = '{4'b0100, O_BR,     32'd1, 16'd2};
        vecs[4]  = '{4'b0001, O_IDLE,   32'd1, 16'd2};
        vecs[5]  = '{4'b0011, O_IDLE,   32'd1, 16'd2};
        vecs[6]  = '{4'b1110, O_FREEZE, 32'd2, 16'd2};
        vecs[7]  = '{4'b0110, O_FREEZE, 32'd3, 16'd2};
        vecs[8]  = '{4'b0111, O_BR,     32'd3, 16'd3};
        vecs[9]  = '{4'b1011, O_LU,     32'd4, 16'd3};
        vecs[10] = '{4'b0010, O_FREEZE, 32'd5, 16'd3};
        vecs[11] = '{4'b1001, O_LU,     32'd6, 16'd3};
        vecs[12] = '{4'b0000, O_IDLE,   32'd6, 16'd3};

        #3;
        check("reset_stall", stall_cnt, 32'd0);
        check("reset_flush", {16'd0, flush_cnt}, 32'd0);
        check("reset_outs", {24'd0, outs}, {24'd0, O_IDLE});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].in);
            check($sformatf("vec%0d_outs", i), {24'd0, outs}, {24'd0, vecs[i].out});
            after_edge();
            check($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].stall);
            check($sformatf("vec%0d_flush", i), {16'd0, flush_cnt}, {16'd0, vecs[i].flush});
        end

        // Three-cycle memory wait then release.
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010);
            check($sformatf("memwait_c%0d", i), {24'd0, outs}, {24'd0, O_FREEZE});
            after_edge();
        end
        drive(4'b0011);
        check("memwait_release", {24'd0, outs}, {24'd0, O_IDLE});
        after_edge();
        check("memwait_stall", stall_cnt, 32'd3);
        drive(4'b0010);
        check("memwait_back_in_run", {24'd0, outs}, {24'd0, O_FREEZE});
        after_edge();

        // Timeout: 16 stalled cycles, then sticky fault.
        pulse_reset();
        for (int i = 1; i <= 16; i++) begin
            drive(4'b0010);
            if (i == 1 || i == 16) begin
                check($sformatf("timeout_c%0d", i), {24'd0, outs}, {24'd0, O_FREEZE});
            end
            after_edge();
        end
        drive(4'b0010);
        check("timeout_fault", {24'd0, outs}, {24'd0, O_FAULT});
        after_edge();
        check("timeout_stall17", stall_cnt, 32'd17);
        drive(4'b1111);
        check("fault_ignores_inputs", {24'd0, outs}, {24'd0, O_FAULT});
        after_edge();
        check("fault_stall18", stall_cnt, 32'd18);
        check("fault_no_flush", {16'd0, flush_cnt}, 32'd0);
        pulse_reset();
        drive(4'b0100);
        check("post_fault_run", {24'd0, outs}, {24'd0, O_BR});
        after_edge();
        check("post_fault_flush", {16'd0, flush_cnt}, 32'd1);

        // Reset abandons an in-progress memory wait.
        for (int i = 0; i < 3; i++) begin
            drive(4'b0010);
            after_edge();
        end
        pulse_reset();
        drive(4'b0001);
        check("reset_mid_wait_run", {24'd0, outs}, {24'd0, O_IDLE});
        after_edge();

        // Saturation of a 4-bit stall counter after 20 stall cycles.
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            drive(4'b1000);
            after_edge();
        end
        check("sat4_stall", {28'd0, stall_cnt4}, 32'h0000_000F);
        check("wide_stall20", stall_cnt, 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stall_controller.md
PIPE_STALL_CONTROLLER -- requirements
Module: pipe_stall_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum wait cycles for mem_ready before fault (range 2..31).
REQ-002 SHALL have parameter CNT_W, default 32: stall_cnt width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port lu_hazard  input  1  load-use hazard detected for the instruction in ID (from hazard detection).
REQ-006 SHALL have port branch_taken  input  1  taken branch/jump resolved in EX this cycle.
REQ-007 SHALL have port mem_req  input  1  MEM stage holds a load/store this cycle.
REQ-008 SHALL have port mem_ready  input  1  data memory completes the MEM access this cycle.
REQ-009 SHALL have port pc_write  output  1  1 = PC updates.
REQ-010 SHALL have port if_id_write  output  1  1 = IF/ID register updates.
REQ-011 SHALL have port id_ex_write  output  1  1 = ID/EX register updates.
REQ-012 SHALL have port ex_mem_write  output  1  1 = EX/MEM register updates.
REQ-013 SHALL have port if_id_flush  output  1  1 = load NOP into IF/ID.
REQ-014 SHALL have port id_ex_flush  output  1  1 = load NOP (bubble) into ID/EX.
REQ-015 SHALL have port mem_wb_bubble  output  1  1 = load NOP into MEM/WB.
REQ-016 SHALL have port fault  output  1  memory-timeout fault, sticky.
REQ-017 SHALL have port stall_cnt  output  CNT_W  count of cycles with pc_write=0.
REQ-018 SHALL have port flush_cnt  output  16  count of branch flushes issued.

Function
REQ-019 SHALL implement FSM states RUN, MEM_WAIT, FAULT; outputs are combinational from state and inputs in the same cycle.
REQ-020 Default outputs in RUN: all *_write=1, all flush/bubble=0.
REQ-021 RUN, mem_req=1 and mem_ready=0: pc_write, if_id_write, id_ex_write, ex_mem_write=0, mem_wb_bubble=1; wait counter loads 1; next state MEM_WAIT. Highest priority; branch_taken and lu_hazard are ignored this cycle.
REQ-022 MEM_WAIT, mem_ready=0: same freeze outputs as REQ-021; wait counter increments; counter reaching MEM_TIMEOUT with mem_ready=0 -> FAULT next cycle.
REQ-023 MEM_WAIT, mem_ready=1: freeze released in this same cycle (RUN outputs, including branch/lu handling per REQ-024/025); next state RUN.
REQ-024 RUN (no memory stall), branch_taken=1: if_id_flush=1, id_ex_flush=1, writes all 1; flush_cnt +1. Branch has priority over lu_hazard.
REQ-025 RUN (no memory stall, no branch), lu_hazard=1: pc_write=0, if_id_write=0, id_ex_flush=1; exactly one bubble per hazard assertion cycle.
REQ-026 FAULT: all *_write=0, all flush/bubble=0, fault=1; exit only by reset; inputs ignored.
REQ-027 stall_cnt increments on every cycle with pc_write=0 (including FAULT); saturates at all-ones.
REQ-028 flush_cnt saturates at 16'hFFFF.
REQ-029 mem_ready asserted without mem_req in RUN SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force state RUN, wait counter 0, stall_cnt 0, flush_cnt 0, fault 0, irrespective of clk.
REQ-031 Reset asserted mid MEM_WAIT or in FAULT SHALL abandon the wait; first cycle after release behaves as RUN.

Structure
REQ-032 State encoding (RUN=0, MEM_WAIT=1, FAULT=2) and MEM_TIMEOUT default SHALL live in shared package pipe_ctrl_pkg.
REQ-033 Both counters SHALL use one sub-module sat_counter (parameterised width, inc, async active-low clear).

Verification
REQ-034 lu_hazard=1 for 1 cycle in RUN -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt 0->1.
REQ-035 branch_taken=1 and lu_hazard=1 same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt 0->1; stall_cnt unchanged.
REQ-036 mem_req=1, mem_ready low 3 cycles then high -> 3 frozen cycles (mem_wb_bubble=1), 4th cycle all writes 1; stall_cnt=3; state RUN.
REQ-037 mem_req=1, mem_ready never high, MEM_TIMEOUT=16 -> fault=1 after 16 stalled cycles, all writes 0 thereafter; rst_n pulse clears fault and counters asynchronously.
REQ-038 branch_taken=1 during MEM_WAIT -> no flush, flush_cnt unchanged; same branch_taken on release cycle -> flush issued.
REQ-039 CNT_W=4, 20 consecutive stall cycles -> stall_cnt holds 4'hF.
